// File: rtl/multi_cycle_adder_pkg.sv
// Shared definitions for the slice-serial adder: FSM state encoding and default geometry.
package multi_cycle_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index register width for n slices; a single slice still needs one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_cycle_adder_slice_adder.sv
// Combinational SLICE-bit ripple-carry adder; also exposes the carry into its MSB for overflow.
module slice_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic w_carry;

    // NOTE: blocking assignments ripple the carry through the loop, and every output gets a default first so no latch is inferred.
    always_comb begin
        w_carry = i_cin;
        o_sum   = '0;
        o_c_msb = i_cin;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) o_c_msb = w_carry;
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/multi_cycle_adder.sv
// Slice-serial add/subtract: one SLICE-bit chunk per clock, result published in a one-cycle DONE state.
module multi_cycle_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("multi_cycle_adder: WIDTH must be a positive multiple of SLICE");
    end

    localparam int               N     = WIDTH / SLICE;
    localparam int               IDX_W = idx_bits(N);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [SLICE-1:0]   w_sum;
    logic               w_cout;
    logic               w_c_msb;
    logic [WIDTH-1:0]   w_result;

    slice_adder #(.SLICE(SLICE)) u_slice (
        .i_a     (r_a[r_idx * SLICE +: SLICE]),
        .i_b     (r_b[r_idx * SLICE +: SLICE]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    // Working register with the current slice merged in, so the last slice lands on s directly.
    always_comb begin
        w_result                         = r_work;
        w_result[r_idx * SLICE +: SLICE] = w_sum;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_work  <= w_result;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_s     <= w_result;
                        r_cout  <= w_cout;
                        r_ovf   <= w_cout ^ w_c_msb;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
